// File: rtl/sdram_cache_pkg.sv
// sdram_cache_pkg
// Shared types and address-field constants for the direct-mapped SDRAM read
// cache (sdram_cache_dm) and its line storage (sdram_cache_ram).
//   state_e   : controller states
//   ADDR_W    : CPU/controller byte-address width
//   DATA_W    : data word width
//   MASK_W    : byte-enable width (one bit per data byte)
//   OFFSET_W  : byte-offset bits below the line index
package sdram_cache_pkg;

    typedef enum logic [2:0] {
        ST_FLUSH  = 3'd0,
        ST_IDLE   = 3'd1,
        ST_LOOKUP = 3'd2,
        ST_MEM    = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    localparam int ADDR_W   = 23;
    localparam int DATA_W   = 32;
    localparam int MASK_W   = DATA_W / 8;
    localparam int OFFSET_W = 2;

    // Tag width left over once the byte offset and the index are removed.
    function automatic int tag_width(input int iw);
        return ADDR_W - OFFSET_W - iw;
    endfunction

endpackage

// File: rtl/sdram_cache_ram.sv
// sdram_cache_ram
// Line storage for the cache: LINES entries of {valid, tag, data}.
// Single port, one access per cycle, synchronous read-before-write.
// Ports:
//   clk       : clock
//   addr_i    : line index for this cycle's read and/or write
//   we_i      : write enable (valid and tag written whole)
//   wvalid_i  : valid bit to write
//   wtag_i    : tag to write
//   wdata_i   : data word to write
//   wbe_i     : byte enables for the data field
//   rvalid_o  : registered valid bit of the line addressed last cycle
//   rtag_o    : registered tag of the line addressed last cycle
//   rdata_o   : registered data of the line addressed last cycle
module sdram_cache_ram
    import sdram_cache_pkg::*;
#(
    parameter int LINES = 256,
    parameter int IW    = $clog2(LINES),
    parameter int TW    = tag_width(IW)
) (
    input  logic              clk,
    input  logic [IW-1:0]     addr_i,
    input  logic              we_i,
    input  logic              wvalid_i,
    input  logic [TW-1:0]     wtag_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [MASK_W-1:0] wbe_i,
    output logic              rvalid_o,
    output logic [TW-1:0]     rtag_o,
    output logic [DATA_W-1:0] rdata_o
);

    logic              valid_q [LINES];
    logic [TW-1:0]     tag_q   [LINES];
    logic [DATA_W-1:0] data_q  [LINES];

    logic              rvalid_q;
    logic [TW-1:0]     rtag_q;
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            valid_q[addr_i] <= wvalid_i;
            tag_q[addr_i]   <= wtag_i;
            for (int b = 0; b < MASK_W; b++) begin
                if (wbe_i[b]) begin
                    data_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
        rvalid_q <= valid_q[addr_i];
        rtag_q   <= tag_q[addr_i];
        rdata_q  <= data_q[addr_i];
    end

    assign rvalid_o = rvalid_q;
    assign rtag_o   = rtag_q;
    assign rdata_o  = rdata_q;

endmodule

// File: rtl/sdram_cache_dm.sv
// sdram_cache_dm
// Direct-mapped, write-through, one-word-per-line read cache between the CPU
// data port and the SDRAM controller. Read hits are served from the line
// store; read misses and all writes go to the controller. Write hits merge
// into the cached line, write misses do not allocate. All lines are
// invalidated after reset and on a flush request.
// Ports:
//   clk, resetn               : clock, synchronous active-low reset
//   cpu_valid/addr/wdata/wmask: CPU request (wmask==0 means read)
//   cpu_rdata, cpu_ready      : read data and one-cycle completion pulse
//   flush, busy               : invalidate-all pulse, sweep in progress
//   mem_valid/addr/din/wmask  : request to the SDRAM controller
//   mem_dout, mem_ready       : controller read data and completion pulse
module sdram_cache_dm
    import sdram_cache_pkg::*;
#(
    parameter int LINES = 256
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cpu_valid,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [MASK_W-1:0] cpu_wmask,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    input  logic              flush,
    output logic              busy,
    output logic              mem_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic [DATA_W-1:0] mem_dout,
    input  logic              mem_ready
);

    localparam int IW = $clog2(LINES);
    localparam int TW = tag_width(IW);
    localparam logic [IW-1:0] CNT_LAST = IW'(LINES - 1);

    state_e            state_q, state_d;
    logic [IW-1:0]     cnt_q, cnt_d;
    logic              flush_pend_q, flush_pend_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
    logic [MASK_W-1:0] req_wmask_q, req_wmask_d;
    logic              hit_q, hit_d;
    logic              cpu_ready_q, cpu_ready_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              mem_valid_q, mem_valid_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_din_q, mem_din_d;
    logic [MASK_W-1:0] mem_wmask_q, mem_wmask_d;

    logic [IW-1:0]     ram_addr;
    logic              ram_we;
    logic              ram_wvalid;
    logic [TW-1:0]     ram_wtag;
    logic [DATA_W-1:0] ram_wdata;
    logic [MASK_W-1:0] ram_wbe;
    logic              ram_rvalid;
    logic [TW-1:0]     ram_rtag;
    logic [DATA_W-1:0] ram_rdata;

    logic [IW-1:0]     req_idx;
    logic [TW-1:0]     req_tag;
    logic              req_is_read;
    logic              lookup_hit;

    assign req_idx     = req_addr_q[IW+OFFSET_W-1:OFFSET_W];
    assign req_tag     = req_addr_q[ADDR_W-1:IW+OFFSET_W];
    assign req_is_read = (req_wmask_q == '0);
    assign lookup_hit  = ram_rvalid && (ram_rtag == req_tag);

    sdram_cache_ram #(
        .LINES (LINES),
        .IW    (IW),
        .TW    (TW)
    ) u_ram (
        .clk      (clk),
        .addr_i   (ram_addr),
        .we_i     (ram_we),
        .wvalid_i (ram_wvalid),
        .wtag_i   (ram_wtag),
        .wdata_i  (ram_wdata),
        .wbe_i    (ram_wbe),
        .rvalid_o (ram_rvalid),
        .rtag_o   (ram_rtag),
        .rdata_o  (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ST_FLUSH;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            cpu_ready_q  <= 1'b0;
            cpu_rdata_q  <= '0;
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            mem_wmask_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            cpu_ready_q  <= cpu_ready_d;
            cpu_rdata_q  <= cpu_rdata_d;
            mem_valid_q  <= mem_valid_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            mem_wmask_q  <= mem_wmask_d;
        end
    end

    // Request latch and lookup result carry no reset: they are only read in
    // states reached after a fresh acceptance.
    always_ff @(posedge clk) begin
        req_addr_q  <= req_addr_d;
        req_wdata_q <= req_wdata_d;
        req_wmask_q <= req_wmask_d;
        hit_q       <= hit_d;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q | flush;
        req_addr_d   = req_addr_q;
        req_wdata_d  = req_wdata_q;
        req_wmask_d  = req_wmask_q;
        hit_d        = hit_q;
        cpu_ready_d  = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        mem_valid_d  = mem_valid_q;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        mem_wmask_d  = mem_wmask_q;
        ram_addr     = req_idx;
        ram_we       = 1'b0;
        ram_wvalid   = 1'b0;
        ram_wtag     = req_tag;
        ram_wdata    = req_wdata_q;
        ram_wbe      = '0;

        case (state_q)
            ST_FLUSH: begin
                ram_addr = cnt_q;
                ram_we   = 1'b1;
                cnt_d    = cnt_q + IW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (flush || flush_pend_q) begin
                    state_d      = ST_FLUSH;
                    cnt_d        = '0;
                    flush_pend_d = 1'b0;
                end else if (cpu_valid && !cpu_ready_q) begin
                    // cpu_ready_q high means the CPU has not yet seen the
                    // completion of the request it is still presenting.
                    req_addr_d  = cpu_addr;
                    req_wdata_d = cpu_wdata;
                    req_wmask_d = cpu_wmask;
                    ram_addr    = cpu_addr[IW+OFFSET_W-1:OFFSET_W];
                    state_d     = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                hit_d = lookup_hit;
                if (req_is_read && lookup_hit) begin
                    cpu_ready_d = 1'b1;
                    cpu_rdata_d = ram_rdata;
                    state_d     = ST_IDLE;
                end else begin
                    mem_valid_d = 1'b1;
                    mem_addr_d  = req_addr_q;
                    mem_din_d   = req_wdata_q;
                    mem_wmask_d = req_wmask_q;
                    state_d     = ST_MEM;
                end
            end
            ST_MEM: begin
                if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    cpu_ready_d = 1'b1;
                    if (req_is_read) begin
                        cpu_rdata_d = mem_dout;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (req_is_read) begin
                    ram_we     = 1'b1;
                    ram_wvalid = 1'b1;
                    ram_wdata  = cpu_rdata_q;
                    ram_wbe    = '1;
                end else if (hit_q) begin
                    ram_we     = 1'b1;
                    ram_wvalid = 1'b1;
                    ram_wdata  = req_wdata_q;
                    ram_wbe    = req_wmask_q;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_FLUSH;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy      = (state_q == ST_FLUSH);
    assign cpu_ready = cpu_ready_q;
    assign cpu_rdata = cpu_rdata_q;
    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;
    assign mem_wmask = mem_wmask_q;

endmodule

// File: tb/tb_sdram_cache_dm.sv
// tb_sdram_cache_dm
// Self-checking bench for sdram_cache_dm: directed scenarios followed by a
// randomized request stream, checked against a word-addressed memory model
// and a line-occupancy model of the cache.
module tb_sdram_cache_dm;

    localparam int LINES = 256;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cpu_valid;
    logic [22:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_wmask;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        flush;
    logic        busy;
    logic        mem_valid;
    logic [22:0] mem_addr;
    logic [31:0] mem_din;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_dout;
    logic        mem_ready;

    always #5 clk = ~clk;

    sdram_cache_dm #(.LINES(LINES)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .cpu_valid (cpu_valid),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_wmask (cpu_wmask),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .flush     (flush),
        .busy      (busy),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_wmask (mem_wmask),
        .mem_dout  (mem_dout),
        .mem_ready (mem_ready)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
        end
    endtask

    // Memory model: word-addressed, unwritten words have a fixed pattern.
    logic [31:0] memw [int];

    function automatic logic [31:0] mrd(input int w);
        if (memw.exists(w)) return memw[w];
        return 32'(w) * 32'h9E3779B1 + 32'h1357;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    // Cache model: which word each line currently holds.
    bit mval  [LINES];
    int mword [LINES];

    function automatic bit model_hit(input int w);
        return mval[w % LINES] && (mword[w % LINES] == w);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < LINES; i++) mval[i] = 1'b0;
    endtask

    // Expected controller request fields and transaction count.
    logic [22:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_mask;
    int          txn = 0;
    bit          req_active = 1'b0;

    // Controller responder: random 0..3 cycle latency, single-cycle ready.
    initial begin
        bit pend;
        int delay;
        pend = 1'b0;
        delay = 0;
        mem_ready = 1'b0;
        mem_dout = '0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (!resetn) begin
                pend = 1'b0;
            end else if (mem_valid) begin
                if (!pend) begin
                    pend = 1'b1;
                    delay = $urandom_range(0, 3);
                end
                if (delay == 0) begin
                    mem_ready = 1'b1;
                    pend = 1'b0;
                    txn++;
                    chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
                    chk("mem_wmask", 32'(mem_wmask), 32'(exp_mask));
                    if (mem_wmask != 4'h0) begin
                        chk("mem_din", mem_din, exp_wdata);
                        memw[int'(mem_addr[22:2])] = merge(mrd(int'(mem_addr[22:2])), mem_din, mem_wmask);
                        mem_dout = $urandom;
                    end else begin
                        mem_dout = mrd(int'(mem_addr[22:2]));
                    end
                end else begin
                    delay--;
                end
            end
        end
    end

    // Every cycle with no request outstanding the cache must stay silent.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (resetn && !req_active) begin
                chk("idle_cpu_ready", 32'(cpu_ready), 32'd0);
                chk("idle_mem_valid", 32'(mem_valid), 32'd0);
            end
        end
    end

    task automatic do_req(input logic [22:0] a, input logic [31:0] wd, input logic [3:0] wm,
                          input bit flush_mid, output logic [31:0] rd, output bit was_hit);
        int          w;
        bit          exp_hit;
        logic [31:0] exp_rd;
        int          t0;
        int          cyc;
        int          mv_first;
        int          mr_idx;
        bit          got;
        bit          fl_done;
        w        = int'(a[22:2]);
        exp_hit  = (wm == 4'h0) && model_hit(w);
        exp_rd   = mrd(w);
        t0       = txn;
        cyc      = 0;
        mv_first = -1;
        mr_idx   = -1;
        got      = 1'b0;
        fl_done  = 1'b0;
        rd       = '0;
        @(negedge clk);
        #1;
        exp_addr = a; exp_wdata = wd; exp_mask = wm;
        req_active = 1'b1;
        cpu_addr = a; cpu_wdata = wd; cpu_wmask = wm; cpu_valid = 1'b1;
        while (!got && cyc < 200) begin
            @(negedge clk);
            #1;
            cyc++;
            if (flush) flush = 1'b0;
            if (mem_valid && mv_first < 0) begin
                mv_first = cyc;
                if (flush_mid && !fl_done) begin
                    flush = 1'b1;
                    fl_done = 1'b1;
                end
            end
            if (mem_ready) mr_idx = cyc;
            if (cpu_ready) begin
                got = 1'b1;
                rd = cpu_rdata;
            end
        end
        cpu_valid = 1'b0;
        flush = 1'b0;
        chk("req_completed", 32'(got), 32'd1);
        if (wm == 4'h0) chk("rdata", rd, exp_rd);
        chk("mem_txn_count", 32'(txn - t0), exp_hit ? 32'd0 : 32'd1);
        if (exp_hit) begin
            chk("hit_latency", 32'(cyc), 32'd2);
        end else begin
            chk("mem_valid_latency", 32'(mv_first), 32'd2);
            chk("ready_after_mem_ready", 32'(cyc), 32'(mr_idx + 1));
        end
        @(negedge clk);
        #1;
        chk("ready_single_cycle", 32'(cpu_ready), 32'd0);
        req_active = 1'b0;
        if (wm == 4'h0) begin
            mval[w % LINES]  = 1'b1;
            mword[w % LINES] = w;
        end
        was_hit = exp_hit;
    endtask

    task automatic wait_flush_done(input string nm);
        int n;
        n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(nm, 32'(busy), 32'd0);
        model_clear();
    endtask

    initial begin
        logic [31:0] rd;
        bit          h;
        int          nb;
        int          t0;
        int          cyc;
        int          run;
        bit          got;

        resetn = 1'b0; cpu_valid = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        cpu_wmask = '0; flush = 1'b0;
        exp_addr = '0; exp_wdata = '0; exp_mask = '0;
        memw[32'h100 >> 2] = 32'hDEADBEEF;
        memw[32'h500 >> 2] = 32'h12345678;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_cpu_ready", 32'(cpu_ready), 32'd0);
        chk("reset_cpu_rdata", cpu_rdata, 32'd0);
        chk("reset_mem_valid", 32'(mem_valid), 32'd0);
        chk("reset_mem_fields", {mem_addr, mem_wmask, 5'd0} | mem_din, 32'd0);
        chk("reset_busy", 32'(busy), 32'd1);
        resetn = 1'b1;

        // Flush sweep after reset; a read issued at cycle 10 must wait it out.
        nb = 0;
        t0 = txn;
        for (int i = 0; i < 256; i++) begin
            if (!busy || cpu_ready) nb++;
            if (i == 10) begin
                exp_addr = 23'h000100; exp_mask = 4'h0; exp_wdata = '0;
                req_active = 1'b1;
                cpu_addr = 23'h000100; cpu_wmask = 4'h0; cpu_wdata = '0;
                cpu_valid = 1'b1;
            end
            @(negedge clk);
            #1;
        end
        chk("reset_busy_window", 32'(nb), 32'd0);
        chk("busy_after_sweep", 32'(busy), 32'd0);
        cyc = 256;
        got = 1'b0;
        rd = '0;
        while (!got && cyc < 400) begin
            if (cpu_ready) begin
                got = 1'b1;
                rd = cpu_rdata;
            end else begin
                @(negedge clk);
                #1;
                cyc++;
            end
        end
        cpu_valid = 1'b0;
        chk("early_req_done_after_flush", 32'(got && cyc > 256), 32'd1);
        chk("early_req_rdata", rd, 32'hDEADBEEF);
        chk("early_req_txn", 32'(txn - t0), 32'd1);
        @(negedge clk);
        #1;
        req_active = 1'b0;
        mval[64] = 1'b1;
        mword[64] = 32'h100 >> 2;

        // Second read of the same address hits.
        do_req(23'h000100, 32'h0, 4'h0, 1'b0, rd, h);
        chk("reread_hit", 32'(h), 32'd1);
        chk("reread_data", rd, 32'hDEADBEEF);

        // Write hit merges byte 1.
        do_req(23'h000100, 32'h0000AB00, 4'b0010, 1'b0, rd, h);
        do_req(23'h000100, 32'h0, 4'h0, 1'b0, rd, h);
        chk("write_hit_then_read_hit", 32'(h), 32'd1);
        chk("write_hit_merged", rd, 32'hDEADABEF);

        // Write miss does not allocate.
        do_req(23'h7FFFFC, 32'hCAFEF00D, 4'hF, 1'b0, rd, h);
        do_req(23'h7FFFFC, 32'h0, 4'h0, 1'b0, rd, h);
        chk("write_miss_no_alloc", 32'(h), 32'd0);
        chk("write_miss_data", rd, 32'hCAFEF00D);

        // Aliasing on index 64.
        for (int k = 0; k < 4; k++) begin
            do_req((k % 2 == 0) ? 23'h000500 : 23'h000100, 32'h0, 4'h0, 1'b0, rd, h);
            chk("alias_miss", 32'(h), 32'd0);
            chk("alias_data", rd, (k % 2 == 0) ? 32'h12345678 : 32'hDEADABEF);
        end

        // Flush arriving during the controller wait.
        do_req(23'h000900, 32'h0, 4'h0, 1'b1, rd, h);
        run = 0;
        for (int i = 0; i < 5 && !busy; i++) begin
            @(negedge clk);
            #1;
        end
        while (busy && run < 300) begin
            run++;
            @(negedge clk);
            #1;
        end
        chk("flush_busy_length", 32'(run), 32'd256);
        model_clear();
        do_req(23'h000100, 32'h0, 4'h0, 1'b0, rd, h);
        chk("read_after_flush_misses", 32'(h), 32'd0);
        chk("read_after_flush_data", rd, 32'hDEADABEF);

        // Randomized traffic over a few aliasing indices and tags.
        for (int n = 0; n < 300; n++) begin
            int          r;
            logic [12:0] tg;
            logic [7:0]  ix;
            logic [1:0]  lo;
            logic [3:0]  wm;
            r = $urandom_range(0, 99);
            if (r < 4) begin
                @(negedge clk);
                #1;
                flush = 1'b1;
                @(negedge clk);
                #1;
                flush = 1'b0;
                wait_flush_done("random_flush_end");
            end else begin
                case ($urandom_range(0, 3))
                    0: tg = 13'h0000;
                    1: tg = 13'h0001;
                    2: tg = 13'h0002;
                    default: tg = 13'h1FFF;
                endcase
                ix = 8'($urandom_range(0, 7));
                lo = 2'($urandom_range(0, 3));
                wm = (r < 60) ? 4'h0 : 4'($urandom_range(1, 15));
                do_req({tg, ix, lo}, $urandom, wm, 1'b0, rd, h);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
